// File: rtl/cpu2_pkg.sv
// Shared widths and load-sequencer state encoding for the CPU2 write-back path.
// Imported by rf_load_fsm and rf_wb_ctrl.
package cpu2_pkg;

    localparam int RF_AW = 4;
    localparam int XLEN  = 32;
    localparam int HW    = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ_LO,
        REQ_HI
    } ld_state_e;

endpackage

// File: rtl/rf_load_fsm.sv
// Splits a 32-bit load into two halfword bus transactions (low, then high)
// and generates the matching halfword RF write in each ack cycle.
import cpu2_pkg::*;

module rf_load_fsm (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_issue,
    input  logic [RF_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]  ld_addr,
    output logic             ld_ready,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [HW-1:0]    mem_rdata,
    output logic             wr_slot,
    output logic             wr_we,
    output logic             wr_hl,
    output logic             hi_done,
    output logic [RF_AW-1:0] wr_rd,
    output logic [XLEN-1:0]  wr_wd
);

    ld_state_e        state;
    ld_state_e        next;
    logic [XLEN-1:0]  addr_q;
    logic [RF_AW-1:0] rd_q;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // Destination and address are captured only when a load is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            rd_q   <= '0;
        end else if (state == IDLE && ld_issue) begin
            addr_q <= ld_addr;
            rd_q   <= ld_rd;
        end
    end

    // Next state, bus request and halfword write slot; acks only count
    // while a transaction is outstanding and reset is low.
    always_comb begin
        next     = state;
        ld_ready = 1'b0;
        mem_req  = 1'b0;
        mem_addr = '0;
        wr_slot  = 1'b0;
        wr_hl    = 1'b0;
        unique case (state)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_issue) next = REQ_LO;
            end
            REQ_LO: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack && !reset) begin
                    wr_slot = 1'b1;
                    next    = REQ_HI;
                end
            end
            REQ_HI: begin
                mem_req  = 1'b1;
                mem_addr = addr_q + 32'd2;
                wr_hl    = 1'b1;
                if (mem_ack && !reset) begin
                    wr_slot = 1'b1;
                    next    = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    assign wr_rd   = rd_q;
    assign wr_we   = wr_slot && (rd_q != '0);
    assign wr_wd   = {{(XLEN-HW){1'b0}}, mem_rdata};
    assign hi_done = wr_slot && wr_hl;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port arbiter: load halfwords, then skidded ALU, then
// direct ALU. Optional load scoreboard enabled by RF_WB_SCOREBOARD_EN.
import cpu2_pkg::*;

module rf_wb_ctrl (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_we,
    input  logic [RF_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_wd,
    output logic             alu_stall,
    input  logic             ld_issue,
    input  logic [RF_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]  ld_addr,
    output logic             ld_ready,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [HW-1:0]    mem_rdata,
    input  logic [RF_AW-1:0] dec_ra1,
    input  logic [RF_AW-1:0] dec_ra2,
    input  logic [RF_AW-1:0] dec_rd,
    output logic             haz_stall,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_wa,
    output logic [XLEN-1:0]  rf_wd,
    output logic             rf_half,
    output logic             rf_hl
);

    logic             ld_slot;
    logic             ld_we;
    logic             ld_hl;
    logic             ld_hi_done;
    logic [RF_AW-1:0] ld_wa;
    logic [XLEN-1:0]  ld_wd;

    logic             skid_valid;
    logic [RF_AW-1:0] skid_rd;
    logic [XLEN-1:0]  skid_wd;

    rf_load_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .ld_issue  (ld_issue),
        .ld_rd     (ld_rd),
        .ld_addr   (ld_addr),
        .ld_ready  (ld_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wr_slot   (ld_slot),
        .wr_we     (ld_we),
        .wr_hl     (ld_hl),
        .hi_done   (ld_hi_done),
        .wr_rd     (ld_wa),
        .wr_wd     (ld_wd)
    );

    // An ALU write colliding with a load halfword parks here for one slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_rd    <= '0;
            skid_wd    <= '0;
        end else if (ld_slot && alu_we && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_rd    <= alu_rd;
            skid_wd    <= alu_wd;
        end else if (skid_valid && !ld_slot) begin
            skid_valid <= 1'b0;
        end
    end

    assign alu_stall = skid_valid;

    // Write-port mux; r0 writes occupy their slot but never assert rf_we.
    always_comb begin
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        rf_half = 1'b0;
        rf_hl   = 1'b0;
        if (!reset) begin
            if (ld_slot) begin
                rf_we   = ld_we;
                rf_wa   = ld_wa;
                rf_wd   = ld_wd;
                rf_half = 1'b1;
                rf_hl   = ld_hl;
            end else if (skid_valid) begin
                rf_we = skid_rd != '0;
                rf_wa = skid_rd;
                rf_wd = skid_wd;
            end else if (alu_we) begin
                rf_we = alu_rd != '0;
                rf_wa = alu_rd;
                rf_wd = alu_wd;
            end
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [15:0] busy;

    // A destination is busy from load acceptance until its high-half write.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (ld_hi_done) busy[ld_wa] <= 1'b0;
            if (ld_issue && ld_ready && ld_rd != '0)
                busy[ld_rd] <= 1'b1;
        end
    end

    assign haz_stall = (ld_issue && !ld_ready)
                     || (dec_ra1 != '0 && busy[dec_ra1])
                     || (dec_ra2 != '0 && busy[dec_ra2])
                     || (dec_rd  != '0 && busy[dec_rd]);
`else
    logic unused_dec;
    assign unused_dec = ^{dec_ra1, dec_ra2, dec_rd, ld_hi_done};
    assign haz_stall  = ld_issue && !ld_ready;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: load sequencing, skid, wrap, r0, reset.
// Hazard expectations follow RF_WB_SCOREBOARD_EN when it is defined.
module tb_rf_wb_ctrl;

`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_we;
    logic [3:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        alu_stall;
    logic        ld_issue;
    logic [3:0]  ld_rd;
    logic [31:0] ld_addr;
    logic        ld_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [3:0]  dec_ra1;
    logic [3:0]  dec_ra2;
    logic [3:0]  dec_rd;
    logic        haz_stall;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_half;
    logic        rf_hl;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rf_wb_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .alu_we    (alu_we),
        .alu_rd    (alu_rd),
        .alu_wd    (alu_wd),
        .alu_stall (alu_stall),
        .ld_issue  (ld_issue),
        .ld_rd     (ld_rd),
        .ld_addr   (ld_addr),
        .ld_ready  (ld_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .dec_ra1   (dec_ra1),
        .dec_ra2   (dec_ra2),
        .dec_rd    (dec_rd),
        .haz_stall (haz_stall),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .rf_half   (rf_half),
        .rf_hl     (rf_hl)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to the next negedge, then let combinational outputs settle.
    task automatic step;
        @(negedge clk);
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        reset = 1; alu_we = 0; alu_rd = 0; alu_wd = 0;
        ld_issue = 0; ld_rd = 0; ld_addr = 0;
        mem_ack = 0; mem_rdata = 0;
        dec_ra1 = 0; dec_ra2 = 0; dec_rd = 0;
        step; step;
        reset = 0; settle;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_rf_wa", 32'(rf_wa), 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_rf_half", 32'(rf_half), 0);
        chk("rst_rf_hl", 32'(rf_hl), 0);
        chk("rst_alu_stall", 32'(alu_stall), 0);
        chk("rst_haz", 32'(haz_stall), 0);
        chk("rst_ld_ready", 32'(ld_ready), 1);

        // Load r5 from 0x100, with ALU r3 colliding on the low ack.
        step; ld_issue = 1; ld_rd = 5; ld_addr = 32'h100; settle;
        chk("l1_issue_ready", 32'(ld_ready), 1);
        chk("l1_issue_haz", 32'(haz_stall), 0);
        step; ld_issue = 0; settle;
        chk("l1_lo_req", 32'(mem_req), 1);
        chk("l1_lo_addr", mem_addr, 32'h100);
        chk("l1_lo_ready", 32'(ld_ready), 0);
        chk("l1_lo_idle_we", 32'(rf_we), 0);
        step; mem_ack = 1; mem_rdata = 16'hBEEF;
        alu_we = 1; alu_rd = 3; alu_wd = 32'hA5A5A5A5; settle;
        chk("l1_lo_we", 32'(rf_we), 1);
        chk("l1_lo_wa", 32'(rf_wa), 5);
        chk("l1_lo_wd", rf_wd, 32'h0000BEEF);
        chk("l1_lo_half", 32'(rf_half), 1);
        chk("l1_lo_hl", 32'(rf_hl), 0);
        chk("l1_lo_stall", 32'(alu_stall), 0);
        step; mem_ack = 0; alu_we = 0; settle;
        chk("skid_stall", 32'(alu_stall), 1);
        chk("skid_we", 32'(rf_we), 1);
        chk("skid_wa", 32'(rf_wa), 3);
        chk("skid_wd", rf_wd, 32'hA5A5A5A5);
        chk("skid_half", 32'(rf_half), 0);
        chk("l1_hi_addr", mem_addr, 32'h102);
        step; settle;
        chk("skid_stall_off", 32'(alu_stall), 0);
        chk("skid_we_off", 32'(rf_we), 0);
        chk("l1_hi_stable", mem_addr, 32'h102);
        chk("l1_hi_req", 32'(mem_req), 1);
        step; mem_ack = 1; mem_rdata = 16'h1234; settle;
        chk("l1_hi_we", 32'(rf_we), 1);
        chk("l1_hi_wa", 32'(rf_wa), 5);
        chk("l1_hi_wd", rf_wd, 32'h00001234);
        chk("l1_hi_hl", 32'(rf_hl), 1);
        chk("l1_hi_ready", 32'(ld_ready), 0);
        step; mem_ack = 0; settle;
        chk("l1_done_ready", 32'(ld_ready), 1);
        chk("l1_done_req", 32'(mem_req), 0);
        chk("l1_done_we", 32'(rf_we), 0);

        // Direct ALU writes while idle; r0 is suppressed.
        alu_we = 1; alu_rd = 9; alu_wd = 32'h0BADF00D; settle;
        chk("alu_we", 32'(rf_we), 1);
        chk("alu_wa", 32'(rf_wa), 9);
        chk("alu_wd", rf_wd, 32'h0BADF00D);
        chk("alu_half", 32'(rf_half), 0);
        step; alu_rd = 0; settle;
        chk("alu_r0_we", 32'(rf_we), 0);
        step; alu_we = 0;

        // Scoreboard: load r7 while decode reads r7.
        ld_issue = 1; ld_rd = 7; ld_addr = 32'h200; settle;
        chk("sb_issue_haz", 32'(haz_stall), 0);
        step; ld_issue = 0; dec_ra2 = 7; settle;
        chk("sb_lo_haz", 32'(haz_stall), 32'(SB));
        step; mem_ack = 1; mem_rdata = 16'h1111; settle;
        chk("sb_loack_haz", 32'(haz_stall), 32'(SB));
        step; mem_ack = 0; settle;
        chk("sb_hi_haz", 32'(haz_stall), 32'(SB));
        step; mem_ack = 1; mem_rdata = 16'h2222; settle;
        chk("sb_hiack_haz", 32'(haz_stall), 32'(SB));
        step; mem_ack = 0; settle;
        chk("sb_after_haz", 32'(haz_stall), 0);
        dec_ra2 = 0;

        // Load to r0 at the top of memory: address wraps, no RF writes.
        step; ld_issue = 1; ld_rd = 0; ld_addr = 32'hFFFFFFFE;
        dec_ra1 = 0;
        step; ld_issue = 0; settle;
        chk("wrap_lo_addr", mem_addr, 32'hFFFFFFFE);
        chk("r0_haz", 32'(haz_stall), 0);
        step; mem_ack = 1; mem_rdata = 16'h3333; settle;
        chk("r0_lo_we", 32'(rf_we), 0);
        chk("r0_lo_half", 32'(rf_half), 1);
        step; mem_ack = 0; settle;
        chk("wrap_hi_addr", mem_addr, 32'h00000000);
        chk("wrap_hi_req", 32'(mem_req), 1);
        step; mem_ack = 1; mem_rdata = 16'h4444; settle;
        chk("r0_hi_we", 32'(rf_we), 0);
        step; mem_ack = 0; settle;
        chk("r0_done_ready", 32'(ld_ready), 1);

        // Reset in REQ_HI: load is abandoned, late ack ignored.
        ld_issue = 1; ld_rd = 4; ld_addr = 32'h300;
        step; ld_issue = 0;
        step; mem_ack = 1; mem_rdata = 16'h5555;
        step; mem_ack = 0; settle;
        chk("rr_in_hi", mem_addr, 32'h302);
        reset = 1;
        step; reset = 0; dec_rd = 4; settle;
        chk("rr_req", 32'(mem_req), 0);
        chk("rr_ready", 32'(ld_ready), 1);
        chk("rr_busy", 32'(haz_stall), 0);
        mem_ack = 1; mem_rdata = 16'h6666; settle;
        chk("rr_late_we", 32'(rf_we), 0);
        step; mem_ack = 0; dec_rd = 0;

        // Issue while busy is refused; reissue after idle is accepted.
        ld_issue = 1; ld_rd = 6; ld_addr = 32'h400;
        step; ld_rd = 8; ld_addr = 32'h500; settle;
        chk("rej_haz", 32'(haz_stall), 1);
        chk("rej_ready", 32'(ld_ready), 0);
        chk("rej_addr", mem_addr, 32'h400);
        step; ld_issue = 0; mem_ack = 1; mem_rdata = 16'h7777;
        step; settle;
        chk("rej_hi_wa", 32'(rf_wa), 6);
        chk("rej_hi_addr", mem_addr, 32'h402);
        step; mem_ack = 0; settle;
        chk("rej_idle", 32'(ld_ready), 1);
        ld_issue = 1;
        step; ld_issue = 0; settle;
        chk("re_addr", mem_addr, 32'h500);
        mem_ack = 1; mem_rdata = 16'h8888;
        step; settle;
        chk("re_hi_wa", 32'(rf_wa), 8);
        chk("re_hi_hl", 32'(rf_hl), 1);
        step; mem_ack = 0; settle;
        chk("re_done", 32'(ld_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-back controller for the 16-entry, 32-bit CPU register file. Owns the single RF write port and shares it between ALU write-back and 32-bit loads, which it sequences as two 16-bit memory transactions: low half first, then high half. Sits between the execute stage, the data-memory bus and the RF write port (`we3`/`ra3`/`wd3`/`highlow`/`memtoreg`/`data_ack_i`). Optionally tracks in-flight load destinations and stalls decode on hazards.

## Interface
- No parameters. Widths are fixed in `cpu2_pkg`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `alu_we`  in  1  ALU write-back request
- `alu_rd`  in  4  ALU destination register
- `alu_wd`  in  32  ALU result
- `alu_stall`  out  1  ALU write-back must be held; `alu_we` must be 0 while this is high
- `ld_issue`  in  1  start a 32-bit load
- `ld_rd`  in  4  load destination register
- `ld_addr`  in  32  load byte address
- `ld_ready`  out  1  load sequencer idle; `ld_issue` is accepted only when this is high
- `mem_req`  out  1  memory request
- `mem_addr`  out  32  halfword address
- `mem_ack`  in  1  data valid on `mem_rdata`; single cycle
- `mem_rdata`  in  16  returned halfword
- `dec_ra1`, `dec_ra2`, `dec_rd`  in  4 each  decode-stage register indices
- `haz_stall`  out  1  decode hazard stall
- `rf_we`  out  1  RF write enable
- `rf_wa`  out  4  RF write address
- `rf_wd`  out  32  RF write data
- `rf_half`  out  1  halfword write (drives `memtoreg` and `data_ack_i`)
- `rf_hl`  out  1  1 = upper half, 0 = lower half

## Operation
- Load FSM states:
  - IDLE
    - `ld_ready`=1.
    - `ld_issue` latches `ld_rd` and `ld_addr`, then goes to REQ_LO.
    - If `ld_rd`=0, the memory transactions still run but the RF write is suppressed.
  - REQ_LO
    - `mem_req`=1, `mem_addr`=addr.
    - On `mem_ack`: write the low half (`rf_we`=1, `rf_half`=1, `rf_hl`=0, `rf_wd`[15:0]=`mem_rdata`), then go to REQ_HI.
  - REQ_HI
    - `mem_req`=1, `mem_addr`=addr+2, modulo 2^32 (0xFFFFFFFE+2 wraps to 0).
    - On `mem_ack`: write the high half (`rf_hl`=1), then go to IDLE.
- Write-port priority: memory-ack write, then skid, then direct ALU write.
- ALU path:
  - If `alu_we` arrives in the same cycle as a memory write, the request is captured into a one-entry skid register. `skid_valid` is set.
  - `alu_stall` = `skid_valid`.
  - The skid drains in the first cycle with no memory ack.
- Writes to r0 are never issued (`rf_we`=0). They still consume their slot.
- `rf_wd`[31:16]=0 during halfword writes; the RF ignores those bits.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `rf_half`=0, `rf_hl`=0, `alu_stall`=0, `haz_stall`=0, `ld_ready`=1. FSM=IDLE, skid empty, busy=0.
- RF write outputs are combinational in the ack cycle. The RF captures on the same edge, so there is zero added latency.
- Minimum load: issue at edge N, `mem_req` from N+1, first ack at N+1 gives the low write; ack at N+2 gives the high write. `ld_ready` is high again at N+3.
- `mem_req` and `mem_addr` stay stable until `mem_ack`.
- Reset mid-load: the FSM returns to IDLE and `mem_req` drops the next cycle. A late ack is ignored.
- Reset takes priority over all inputs.

## Configuration
- `RF_WB_SCOREBOARD_EN` defined:
  - 16-bit `busy` vector. The bit is set on `ld_issue` (if `ld_rd`≠0) and cleared on the high-half ack.
  - `haz_stall` = OR of `busy[x]` for x in {`dec_ra1`, `dec_ra2`, `dec_rd`} with x≠0, or (`ld_issue` & !`ld_ready`).
- `RF_WB_SCOREBOARD_EN` undefined:
  - No busy vector.
  - `haz_stall` = `ld_issue` & !`ld_ready`.

## Structure
- `cpu2_pkg`:
  - `RF_AW`=4, `XLEN`=32, `HW`=16.
  - Load FSM state enum: IDLE, REQ_LO, REQ_HI.
- Sub-module `rf_load_fsm`: FSM, address/destination latch and halfword write generation.
- The top level holds the skid, the priority mux and the scoreboard.

## Test plan
- Load `ld_addr`=0x100 into r5, with acks returning 0xBEEF then 0x1234 → `mem_addr` 0x100 then 0x102. Writes: r5 low half 0xBEEF, then high half 0x1234 (`rf_hl`=0 then 1). `ld_ready` returns after the second ack.
- ALU write r3=0xA5A5A5A5 in the same cycle as the low-half ack → memory write first. Next cycle r3 is written from the skid; `alu_stall`=1 for exactly one cycle.
- With `RF_WB_SCOREBOARD_EN`: load to r7 in flight and `dec_ra2`=7 → `haz_stall`=1 until the high-half ack cycle, 0 the cycle after. `dec_ra1`=0 never stalls.
- `ld_addr`=0xFFFFFFFE → second `mem_addr`=0x00000000. A load to r0 gives two memory transactions and `rf_we`=0 throughout.
- `reset` asserted in REQ_HI with no ack → next cycle `mem_req`=0, `ld_ready`=1, busy=0. An ack arriving afterward produces no RF write.
- `ld_issue` while in REQ_LO → not accepted, `haz_stall`=1. Reissuing after IDLE starts a new sequence.
